bist_engine: RTL and testbench

//  Parametrised self-test engine: start/done handshake, pass/fail signature check, abort.

---
 rtl/bist_engine.sv | 125 ++++++++++++
 tb/tb_bist_engine.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bist_engine.sv
// bist_engine: LFSR pattern source plus MISR response compactor with a
// start/done handshake, abort, and a pass/fail compare against GOLDEN.
// The CUT sits combinationally between pat_o and resp_i.
module bist_engine #(
  parameter int unsigned         LFSR_W    = 5,
  parameter logic [LFSR_W-1:0]   LFSR_TAPS = 5'b10100,
  parameter logic [LFSR_W-1:0]   SEED      = 5'b00001,
  parameter int unsigned         MISR_W    = 4,
  parameter logic [MISR_W-1:0]   MISR_TAPS = 4'b1001,
  parameter int unsigned         CUT_W     = 1,
  parameter int unsigned         PATTERNS  = 31,
  parameter logic [MISR_W-1:0]   GOLDEN    = 4'h0
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic              start,
  input  logic              abort,
  input  logic [CUT_W-1:0]  resp_i,
  output logic [LFSR_W-1:0] pat_o,
  output logic              pat_vld,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [MISR_W-1:0] sig_o
);

  localparam int unsigned      CNT_W    = $clog2(PATTERNS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PATTERNS - 1);

  // Parameter sanity: an all-zero seed locks the LFSR, and the response
  // must fit inside the signature register.
  if (SEED == '0) begin : g_bad_seed
    $error("bist_engine: SEED must be nonzero");
  end
  if (CUT_W < 1 || CUT_W > MISR_W) begin : g_bad_cut_w
    $error("bist_engine: CUT_W must satisfy 1 <= CUT_W <= MISR_W");
  end
  if (PATTERNS < 1) begin : g_bad_patterns
    $error("bist_engine: PATTERNS must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              load;
  logic              step;
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;
  logic [MISR_W-1:0] misr;
  logic [MISR_W-1:0] misr_nxt;
  logic [CNT_W-1:0]  cnt;

  // Next-value functions of the pattern generator and the compactor.
  always_comb begin
    lfsr_nxt = {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
    misr_nxt = {misr[MISR_W-2:0], ^(misr & MISR_TAPS)} ^ MISR_W'(resp_i);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; load reinitialises the datapath on start and on
  // abort, step advances it by one compacted pattern.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    unique case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          load      = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_LAST) begin
            state_nxt = ST_DONE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath registers: frozen unless loading or stepping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      lfsr <= SEED;
      misr <= '0;
      cnt  <= '0;
    end else if (load) begin
      lfsr <= SEED;
      misr <= '0;
      cnt  <= '0;
    end else if (step) begin
      lfsr <= lfsr_nxt;
      misr <= misr_nxt;
      cnt  <= cnt + CNT_W'(1);
    end
  end

  assign pat_o   = lfsr;
  assign sig_o   = misr;
  assign busy    = (state == ST_RUN);
  assign pat_vld = busy;
  assign done    = (state == ST_DONE);
  assign pass    = done && (misr == GOLDEN);

endmodule

// File: tb/tb_bist_engine.sv
// Self-checking bench for bist_engine: two instances (GOLDEN=0 and GOLDEN=F)
// share stimulus and are compared every cycle against a behavioural model,
// with directed literal checks on top.
module tb_bist_engine;

  localparam logic [4:0] SEED_V = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [0:0] resp_i = 1'b0;

  logic [4:0] pat_o,   pat_o_f;
  logic       pat_vld, pat_vld_f;
  logic       busy,    busy_f;
  logic       done,    done_f;
  logic       pass,    pass_f;
  logic [3:0] sig_o,   sig_o_f;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // pat_o values seen while pat_vld, in order, for the current run
  logic [4:0] seen[$];

  always #5 clk = ~clk;

  bist_engine dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .resp_i(resp_i),
    .pat_o(pat_o), .pat_vld(pat_vld), .busy(busy), .done(done), .pass(pass),
    .sig_o(sig_o)
  );

  bist_engine #(.GOLDEN(4'hF)) dut_f (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort), .resp_i(resp_i),
    .pat_o(pat_o_f), .pat_vld(pat_vld_f), .busy(busy_f), .done(done_f),
    .pass(pass_f), .sig_o(sig_o_f)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 idle, 1 running, 2 finished; applied counts compacted patterns.
  int         m_mode;
  int         m_applied;
  logic [4:0] m_pat;
  logic [3:0] m_sig;

  function automatic logic [4:0] next_pat(input logic [4:0] p);
    // x^5 + x^3 + 1: feedback is bit4 xor bit2, shifted in at the bottom
    return ((p << 1) & 5'h1F) | 5'(p[4] ^ p[2]);
  endfunction

  function automatic logic [3:0] next_sig(input logic [3:0] s, input logic r);
    return (((s << 1) & 4'hF) | 4'(s[3] ^ s[0])) ^ 4'(r);
  endfunction

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_mode <= 0; m_applied <= 0; m_pat <= SEED_V; m_sig <= '0;
    end else if (m_mode == 1) begin
      if (abort) begin
        m_mode <= 0; m_applied <= 0; m_pat <= SEED_V; m_sig <= '0;
      end else begin
        m_pat     <= next_pat(m_pat);
        m_sig     <= next_sig(m_sig, resp_i[0]);
        m_applied <= m_applied + 1;
        if (m_applied + 1 == 31) m_mode <= 2;
      end
    end else if (start) begin
      m_mode <= 1; m_applied <= 0; m_pat <= SEED_V; m_sig <= '0;
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pat_o",   pat_o,   m_pat);
      chk("pat_vld", pat_vld, m_mode == 1);
      chk("busy",    busy,    m_mode == 1);
      chk("done",    done,    m_mode == 2);
      chk("pass",    pass,    (m_mode == 2) && (m_sig == 4'h0));
      chk("sig_o",   sig_o,   m_sig);
      chk("f.pat_o", pat_o_f, m_pat);
      chk("f.busy",  busy_f,  m_mode == 1);
      chk("f.vld",   pat_vld_f, m_mode == 1);
      chk("f.done",  done_f,  m_mode == 2);
      chk("f.pass",  pass_f,  (m_mode == 2) && (m_sig == 4'hF));
      chk("f.sig_o", sig_o_f, m_sig);
    end
    if (pat_vld) seen.push_back(pat_o);
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    seen.delete();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!done && n < limit) begin
      step();
      n++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_done: timeout after %0d cycles", limit);
    end
  endtask

  initial begin
    // reset state
    repeat (3) step();
    chk("rst pat_o", pat_o, 5'h01);
    chk("rst sig_o", sig_o, 4'h0);
    chk("rst busy",  busy,  1'b0);
    chk("rst done",  done,  1'b0);
    chk("rst pass",  pass,  1'b0);
    rst_b  = 1'b1;
    chk_en = 1'b1;
    step();

    // 1/2: full run with zero response
    pulse_start();
    wait_done(40);
    chk("t2 count", seen.size(), 31);
    if (seen.size() >= 5) begin
      chk("t1 p0", seen[0], 5'h01);
      chk("t1 p1", seen[1], 5'h02);
      chk("t1 p2", seen[2], 5'h04);
      chk("t1 p3", seen[3], 5'h09);
      chk("t1 p4", seen[4], 5'h12);
    end
    chk("t1 wrap",  pat_o,  5'h01);
    chk("t2 sig",   sig_o,  4'h0);
    chk("t2 pass",  pass,   1'b1);
    chk("t2 busy",  busy,   1'b0);
    chk("t3 passf", pass_f, 1'b0);

    // 3: done/pass held through idle cycles, then rerun
    repeat (10) step();
    chk("t3 done hold", done_f, 1'b1);
    chk("t3 pass hold", pass_f, 1'b0);
    pulse_start();
    chk("t3 rerun busy", busy, 1'b1);
    wait_done(40);
    chk("t3 rerun count", seen.size(), 31);

    // 4: response 1 on the first compacted pattern only
    seen.delete();
    start  = 1'b1;
    resp_i = 1'b1;
    step();
    start = 1'b0;
    step();
    resp_i = 1'b0;
    wait_done(40);
    chk("t4 sig",   sig_o,  4'h1);
    chk("t4 pass",  pass,   1'b0);
    chk("t4 passf", pass_f, 1'b0);

    // 5: abort partway through
    pulse_start();
    for (int i = 0; i < 40 && seen.size() < 10; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("t5 busy",  busy,  1'b0);
    chk("t5 done",  done,  1'b0);
    chk("t5 pat_o", pat_o, 5'h01);
    chk("t5 sig",   sig_o, 4'h0);
    repeat (3) step();
    pulse_start();
    wait_done(40);
    chk("t5 count", seen.size(), 31);

    // 6a: start held during RUN is ignored
    pulse_start();
    repeat (4) step();
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    wait_done(40);
    chk("t6 count", seen.size(), 31);

    // 6b: asynchronous reset mid-run
    pulse_start();
    repeat (5) step();
    rst_b = 1'b0;
    #1;
    chk("t6 rst busy",  busy,  1'b0);
    chk("t6 rst pat_o", pat_o, 5'h01);
    chk("t6 rst sig",   sig_o, 4'h0);
    chk("t6 rst done",  done,  1'b0);
    step();
    rst_b = 1'b1;
    step();
    pulse_start();
    wait_done(40);
    chk("t6 post count", seen.size(), 31);
    chk("t6 post pass",  pass, 1'b1);

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
